elelock_ng: RTL

ELELOCK_NG -- requirements
Module: elelock_ng

---
 rtl/elelock_ng.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/elelock_ng.sv
// Keypad code lock: BCD entry shift register, unlock compare, code programming
// and a timed lockout after repeated wrong entries.
module elelock_ng #(
  parameter int                  DIGITS      = 4,
  parameter logic [4*DIGITS-1:0] SECRET      = 16'h1799,
  parameter int                  MAX_FAIL    = 3,
  parameter int                  LOCKOUT_CYC = 16
) (
  input  logic                  ck,
  input  logic                  reset,
  input  logic [9:0]            tenkey,
  input  logic                  close,
  input  logic                  setmode,
  output logic                  lock,
  output logic                  alarm,
  output logic [4*DIGITS-1:0]   key
);

  localparam int          KW      = 4 * DIGITS;
  localparam logic [3:0]  LAST    = 4'(DIGITS - 1);
  localparam logic [3:0]  CNT_MAX = 4'(DIGITS);
  localparam logic [3:0]  MAXF    = 4'(MAX_FAIL);
  localparam logic [15:0] LO_INIT = 16'(LOCKOUT_CYC - 1);
  localparam logic [KW-1:0] ALL_F = {KW{1'b1}};

  typedef enum logic [1:0] {LOCKED, OPEN, PROG, LOCKOUT} state_t;

  state_t        state_q, state_d;
  logic [KW-1:0] key_q, key_d;
  logic [KW-1:0] code_q, code_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [3:0]    fail_q, fail_d;
  logic [15:0]   lo_q, lo_d;
  logic [9:0]    tenkey_q;

  logic          press;
  logic [3:0]    digit;
  logic [KW-1:0] shifted;
  logic [3:0]    fail_inc;

  // A press is a clean one-hot edge out of an idle keypad.
  assign press    = $onehot(tenkey) && (tenkey_q == 10'd0);
  assign shifted  = KW'({key_q, digit});
  assign fail_inc = (fail_q == 4'hF) ? fail_q : fail_q + 4'd1;
  assign key      = key_q;

  always_comb begin
    digit = 4'd0;
    for (int i = 0; i < 10; i++)
      if (tenkey[i]) digit = 4'(i);
  end

  always_ff @(posedge ck or posedge reset) begin
    if (reset) begin
      state_q  <= LOCKED;
      key_q    <= ALL_F;
      code_q   <= SECRET;
      cnt_q    <= 4'd0;
      fail_q   <= 4'd0;
      lo_q     <= 16'd0;
      tenkey_q <= 10'd0;
    end else begin
      state_q  <= state_d;
      key_q    <= key_d;
      code_q   <= code_d;
      cnt_q    <= cnt_d;
      fail_q   <= fail_d;
      lo_q     <= lo_d;
      tenkey_q <= tenkey;
    end
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    fail_d  = fail_q;
    lo_d    = lo_q;
    lock    = 1'b1;
    alarm   = 1'b0;
    case (state_q)
      LOCKED: begin
        if (close) begin
          key_d = ALL_F;
          cnt_d = 4'd0;
        end else if (press) begin
          if (cnt_q == LAST) begin
            key_d = ALL_F;
            cnt_d = 4'd0;
            if (shifted == code_q) begin
              state_d = OPEN;
              fail_d  = 4'd0;
            end else begin
              fail_d = fail_inc;
              if (fail_inc >= MAXF) begin
                state_d = LOCKOUT;
                lo_d    = LO_INIT;
              end
            end
          end else begin
            key_d = shifted;
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      OPEN: begin
        lock = 1'b0;
        if (close) begin
          state_d = LOCKED;
          key_d   = ALL_F;
          cnt_d   = 4'd0;
        end else if (setmode) begin
          state_d = PROG;
          key_d   = ALL_F;
          cnt_d   = 4'd0;
        end else if (press) begin
          key_d = shifted;
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + 4'd1;
        end
      end
      PROG: begin
        lock = 1'b0;
        if (close) begin
          state_d = LOCKED;
          key_d   = ALL_F;
          cnt_d   = 4'd0;
        end else if (press) begin
          if (cnt_q == LAST) begin
            code_d  = shifted;
            state_d = OPEN;
            key_d   = ALL_F;
            cnt_d   = 4'd0;
          end else begin
            key_d = shifted;
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      LOCKOUT: begin
        alarm = 1'b1;
        if (lo_q == 16'd0) begin
          state_d = LOCKED;
          fail_d  = 4'd0;
        end else begin
          lo_d = lo_q - 16'd1;
        end
      end
      default: state_d = LOCKED;
    endcase
  end

endmodule
